// File: rtl/axis_fifo.sv
// Single-clock valid/ready FIFO, DEPTH = 2**ADDR_WIDTH words, no bypass paths.
// Define AXIS_FIFO_LEVEL_EN to build the registered occupancy counter on `level`.
module axis_fifo #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [WIDTH-1:0]      odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;

  // Extra MSB distinguishes full from empty when the low address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // Flags depend on registered pointers only, so no input reaches an output.
  assign iready = !full;
  assign ovalid = !empty;
  assign odata  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign push = ivalid && !full;
  assign pop  = oready && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately left unreset; the pointers alone define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr[ADDR_WIDTH-1:0]] <= idata;
  end

`ifdef AXIS_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + PTR_ONE;
    end else if (pop && !push) begin
      level_q <= level_q - PTR_ONE;
    end
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule
